// File: rtl/dca_matrix_lsu_txn_sched.sv
// Matrix LSU read-path transaction scheduler: walks rows, emits capped AXI burst descriptors.
// Optional 4 KB boundary splitting is enabled by defining DCA_LSU_TXN_4KB_SPLIT_EN.
//
// state | meaning
// IDLE  | waiting for an instruction, inst_ready high
// CALC  | size the next burst from remaining beats, cap and 4 KB distance
// ISSUE | descriptor presented, held until txn_ready
// DONE  | one-cycle completion pulse
module dca_matrix_lsu_txn_sched #(
    parameter int BW_AXI_ADDR    = 32,
    parameter int BW_AXI_DATA    = 32,
    parameter int ELEM_SIZE_LOG2 = 2,
    parameter int BW_NUM_ROW     = 8,
    parameter int BW_NUM_COL     = 8,
    parameter int MAX_BURST      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inst_valid,
    output logic                   inst_ready,
    input  logic [BW_AXI_ADDR-1:0] inst_addr,
    input  logic [BW_AXI_ADDR-1:0] inst_stride,
    input  logic [BW_NUM_ROW-1:0]  inst_num_row_m1,
    input  logic [BW_NUM_COL-1:0]  inst_num_col_m1,
    output logic                   txn_valid,
    input  logic                   txn_ready,
    output logic [BW_AXI_ADDR+2:0] txn_bitaddr,
    output logic [7:0]             txn_alen,
    output logic                   txn_last_row,
    output logic                   txn_last_inst,
    output logic                   busy,
    output logic                   done
);

    localparam int BPB      = BW_AXI_DATA / 8;
    localparam int BPB_LOG2 = $clog2(BPB);
    localparam int CW       = BW_NUM_COL + ELEM_SIZE_LOG2 + 1;
    localparam int MW       = (CW > 13) ? CW : 13;
    localparam int BURST_W  = 9;

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} state_t;

    state_t                 state;
    logic [BW_AXI_ADDR-1:0] stride_q;
    logic [BW_NUM_ROW-1:0]  num_row_q;
    logic [BW_NUM_COL-1:0]  num_col_q;
    logic [BW_AXI_ADDR-1:0] row_base;
    logic [BW_AXI_ADDR-1:0] cur_addr;
    logic [BW_NUM_ROW-1:0]  row_cnt;
    logic [CW-1:0]          rem;
    logic [BURST_W-1:0]     burst_q;
    logic [MW-1:0]          burst_c;

    // Beats per row: element bytes rounded up to whole bus beats.
    function automatic logic [CW-1:0] calc_rem(input logic [BW_NUM_COL-1:0] c);
        logic [CW-1:0] bytes;
        bytes = (CW'(c) + CW'(1)) << ELEM_SIZE_LOG2;
        return (bytes + CW'(BPB - 1)) >> BPB_LOG2;
    endfunction

    always_comb begin
        burst_c = (MW'(rem) < MW'(MAX_BURST)) ? MW'(rem) : MW'(MAX_BURST);
`ifdef DCA_LSU_TXN_4KB_SPLIT_EN
        begin
            logic [MW-1:0] to4k;
            to4k = MW'((13'h1000 - {1'b0, cur_addr[11:0]}) >> BPB_LOG2);
            if (to4k < burst_c) burst_c = to4k;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            stride_q      <= '0;
            num_row_q     <= '0;
            num_col_q     <= '0;
            row_base      <= '0;
            cur_addr      <= '0;
            row_cnt       <= '0;
            rem           <= '0;
            burst_q       <= '0;
            inst_ready    <= 1'b1;
            txn_valid     <= 1'b0;
            txn_bitaddr   <= '0;
            txn_alen      <= '0;
            txn_last_row  <= 1'b0;
            txn_last_inst <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_valid) begin
                        stride_q   <= inst_stride;
                        num_row_q  <= inst_num_row_m1;
                        num_col_q  <= inst_num_col_m1;
                        row_base   <= inst_addr & ~(BW_AXI_ADDR'(BPB - 1));
                        cur_addr   <= inst_addr & ~(BW_AXI_ADDR'(BPB - 1));
                        row_cnt    <= '0;
                        rem        <= calc_rem(inst_num_col_m1);
                        inst_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    burst_q       <= BURST_W'(burst_c);
                    txn_bitaddr   <= {cur_addr, 3'b000};
                    txn_alen      <= 8'(burst_c - MW'(1));
                    txn_last_row  <= (burst_c == MW'(rem));
                    txn_last_inst <= (burst_c == MW'(rem)) && (row_cnt == num_row_q);
                    txn_valid     <= 1'b1;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    if (txn_ready) begin
                        txn_valid <= 1'b0;
                        rem       <= rem - CW'(burst_q);
                        cur_addr  <= cur_addr + (BW_AXI_ADDR'(burst_q) << BPB_LOG2);
                        if (!txn_last_row) begin
                            state <= CALC;
                        end else if (txn_last_inst) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            row_base <= row_base + stride_q;
                            cur_addr <= row_base + stride_q;
                            row_cnt  <= row_cnt + BW_NUM_ROW'(1);
                            rem      <= calc_rem(num_col_q);
                            state    <= CALC;
                        end
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    inst_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
